// File: rtl/ram_read_streamer.sv
// Burst reader: streams a run of sync-read RAM words out over valid/ready.
// Hosts may write the RAM through this block while no burst is running.
module ram_read_streamer #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [AWIDTH-1:0] base_addr_i,
  input  logic [AWIDTH:0]   length_i,
  input  logic              wr_en_i,
  input  logic [AWIDTH-1:0] wr_addr_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  output logic              wr_accept_o,
  output logic [AWIDTH-1:0] ram_addr_o,
  output logic [DWIDTH-1:0] ram_din_o,
  output logic              ram_we_o,
  input  logic [DWIDTH-1:0] ram_dout_i,
  output logic              m_valid_o,
  output logic [DWIDTH-1:0] m_data_o,
  output logic              m_last_o,
  input  logic              m_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [AWIDTH:0]   ONE_L = 1;
  localparam logic [AWIDTH-1:0] ONE_A = 1;

  logic [1:0]        state_q, state_d;
  logic [AWIDTH:0]   rem_q, rem_d;
  logic [AWIDTH-1:0] ptr_q, ptr_d;
  logic              infl_q, infl_d;
  logic              infl_last_q, infl_last_d;
  logic              done_q, done_d;
  logic [AWIDTH-1:0] addr_q;

  logic [DWIDTH-1:0] fdata_q [2];
  logic              flast_q [2];
  logic              rd_q, wr_q;
  logic [1:0]        cnt_q;

  logic              idle, go, zero, pop;
  logic [2:0]        occ;
  logic              rd_issue, issue, issue_last;
  logic [AWIDTH-1:0] issue_addr;

  // The first read of a burst is issued in the start cycle itself so the
  // first beat appears two cycles later; reset gates all request paths.
  always_comb begin
    idle        = (state_q == IDLE) && !reset_i;
    go          = idle && start_i && (length_i != '0);
    zero        = idle && start_i && (length_i == '0);
    wr_accept_o = idle && wr_en_i && !start_i;
    m_valid_o   = (cnt_q != 2'd0);
    m_data_o    = fdata_q[rd_q];
    m_last_o    = m_valid_o && flast_q[rd_q];
    pop         = m_valid_o && m_ready_i;
    occ         = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
    rd_issue    = (state_q == READ) && (rem_q != '0) && (occ < 3'd2);
    issue       = go || rd_issue;
    issue_addr  = go ? base_addr_i : ptr_q;
    issue_last  = go ? (length_i == ONE_L) : (rem_q == ONE_L);
    ram_we_o    = wr_accept_o;
    ram_din_o   = wr_accept_o ? wr_data_i : '0;
    ram_addr_o  = wr_accept_o ? wr_addr_i :
                  issue       ? issue_addr : addr_q;
    busy_o      = (state_q != IDLE);
    done_o      = done_q;
  end

  // Burst sequencing: remaining count, read pointer and state.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    ptr_d       = ptr_q;
    infl_d      = issue;
    infl_last_d = issue && issue_last;
    done_d      = zero;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          rem_d   = length_i - ONE_L;
          ptr_d   = base_addr_i + ONE_A;
          state_d = (length_i == ONE_L) ? DRAIN : READ;
        end
      end
      READ: begin
        if (rd_issue) begin
          rem_d = rem_q - ONE_L;
          ptr_d = ptr_q + ONE_A;
          if (rem_q == ONE_L) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last_o) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      ptr_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      ptr_q       <= ptr_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
      addr_q      <= ram_addr_o;
    end
  end

  // Two-entry output FIFO; issue throttling keeps it from overflowing.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fdata_q[0] <= '0;
      fdata_q[1] <= '0;
      flast_q[0] <= 1'b0;
      flast_q[1] <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      if (infl_q) begin
        fdata_q[wr_q] <= ram_dout_i;
        flast_q[wr_q] <= infl_last_q;
        wr_q          <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

endmodule
